// File: rtl/ahb_sub_sram.sv
`default_nettype none
// ============================================================================
// ahb_sub_sram : AHB-Lite subordinate in front of a word-organised SRAM, with
//                programmable wait states and a two-cycle ERROR response.
// Revision     : 1.0
// ============================================================================
module ahb_sub_sram #(
  parameter int XLEN       = 64,
  parameter int PA_BITS    = 32,
  parameter int DEPTH      = 1024,
  parameter int WAITSTATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic                HREADY,
  input  logic [XLEN-1:0]     HWDATA,
  input  logic [XLEN/8-1:0]   HWSTRB,
  output logic [XLEN-1:0]     HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [IW-1:0]   idx_q;
  logic            wr_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] mem [DEPTH];

  logic [IW-1:0]   addr_idx;
  logic [OFF-1:0]  amask;
  logic            range_err, align_err, size_err, err;
  logic            can_acc, accept, commit, load_new, load_wait, load;
  logic [IW-1:0]   load_idx;
  logic [XLEN-1:0] rd_word;
  logic            unused;

  assign unused   = HTRANS[0];
  assign addr_idx = HADDR[OFF +: IW];

  always_comb begin
    amask = '0;
    for (int i = 0; i < OFF; i++)
      if (i < int'(HSIZE)) amask[i] = 1'b1;
  end

  assign range_err = (HADDR >> (OFF + IW)) != '0;
  assign align_err = |(HADDR[OFF-1:0] & amask);
  assign size_err  = HSIZE > 3'(OFF);
  assign err       = range_err | align_err | size_err;

  // WAIT and ERR1 can never accept, even if an external HREADY misbehaves.
  assign can_acc = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept  = can_acc & HSEL & HREADY & HTRANS[1];

  assign commit    = (state == S_DATA) & wr_q;
  assign load_new  = accept & ~err & ~HWRITE & (WAITSTATES == 0);
  assign load_wait = (state == S_WAIT) & (cnt == 4'd0) & ~wr_q;
  assign load      = load_new | load_wait;
  assign load_idx  = load_wait ? idx_q : addr_idx;

  // Forward bytes of a write committing on this same edge so a read is never stale.
  always_comb begin
    rd_word = mem[load_idx];
    if (commit && (idx_q == load_idx)) begin
      for (int b = 0; b < NB; b++)
        if (HWSTRB[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          if (err) begin
            state_n = S_ERR1;
          end else if (WAITSTATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = WS_LOAD;
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_n = S_DATA;
        else             cnt_n   = cnt - 4'd1;
      end
      S_ERR1:  state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q <= addr_idx;
        wr_q  <= HWRITE;
      end
      if (load) rdata_q <= rd_word;
    end
  end

  // SRAM contents survive reset; a write caught by reset is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit) begin
      for (int b = 0; b < NB; b++)
        if (HWSTRB[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
    end
  end

  assign HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign HRDATA    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sub_sram.sv
`default_nettype none
// Bench for ahb_sub_sram: one zero-wait and one three-wait instance, checked
// against a scoreboard of expected data-phase results.
module tb_ahb_sub_sram;

  localparam int DEPTH = 1024;

  typedef struct {
    string       tag;
    logic        resp;
    logic        chk;
    logic [63:0] data;
    int          waits;
  } exp_t;

  logic        clk;
  logic        rstn      [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [63:0] hwdata    [2];
  logic [7:0]  hwstrb    [2];
  logic [63:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  exp_t        sbq [$];
  logic [63:0] mdl [int];
  logic [63:0] last_rd [2];
  logic        active  [2];
  int          lowcnt  [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  ahb_sub_sram #(.XLEN(64), .PA_BITS(32), .DEPTH(DEPTH), .WAITSTATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HREADY(hreadyout[0]), .HWDATA(hwdata[0]),
    .HWSTRB(hwstrb[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  ahb_sub_sram #(.XLEN(64), .PA_BITS(32), .DEPTH(DEPTH), .WAITSTATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HREADY(hreadyout[1]), .HWDATA(hwdata[1]),
    .HWSTRB(hwstrb[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Data-phase monitor: counts wait cycles and compares on completion.
  initial begin
    exp_t e;
    active = '{1'b0, 1'b0};
    lowcnt = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rstn[d] !== 1'b1) begin
          active[d] = 1'b0;
          lowcnt[d] = 0;
          sbq.delete();
        end else begin
          if (active[d]) begin
            if (hreadyout[d]) begin
              if (sbq.size() == 0) begin
                chk_eq("sb_empty", 64'(sbq.size()), 64'd1);
              end else begin
                e = sbq.pop_front();
                chk_eq({e.tag, "_resp"}, 64'(hresp[d]), 64'(e.resp));
                chk_eq({e.tag, "_waits"}, 64'(lowcnt[d]), 64'(e.waits));
                if (e.chk) chk_eq({e.tag, "_data"}, hrdata[d], e.data);
              end
              lowcnt[d] = 0;
            end else begin
              lowcnt[d]++;
              if (sbq.size() > 0) chk_eq({sbq[0].tag, "_resp_low"}, 64'(hresp[d]), 64'(sbq[0].resp));
            end
          end
          if (hreadyout[d]) active[d] = hsel[d] & htrans[d][1];
        end
      end
    end
  end

  function automatic exp_t predict(input int d, input logic [31:0] a, input logic w,
                                   input logic [2:0] sz, input logic [63:0] wd,
                                   input logic [7:0] st, input string tag);
    exp_t        e;
    logic        err;
    int          key;
    logic [63:0] m;
    err = (a >= 32'(DEPTH * 8)) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0) || (sz > 3'd3);
    key = d * 4096 + int'(a[12:3]);
    e.tag   = tag;
    e.resp  = err;
    e.waits = err ? 1 : ws_of(d);
    e.chk   = !w;
    e.data  = '0;
    if (!w) begin
      e.data = err ? last_rd[d] : mdl[key];
      if (!err) last_rd[d] = e.data;
    end else if (!err) begin
      m = mdl.exists(key) ? mdl[key] : 64'd0;
      for (int b = 0; b < 8; b++)
        if (st[b]) m[b*8 +: 8] = wd[b*8 +: 8];
      mdl[key] = m;
    end
    return e;
  endfunction

  task automatic wait_ready(input int d);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hreadyout[d]) break;
    end
    chk_eq("ready_bound", 64'(hreadyout[d]), 64'd1);
  endtask

  task automatic addr_phase(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel[d]   = 1'b1;
    htrans[d] = 2'b10;
    haddr[d]  = a;
    hwrite[d] = w;
    hsize[d]  = sz;
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [63:0] wd, input logic [7:0] st, input string tag);
    sbq.push_back(predict(d, a, w, sz, wd, st, tag));
    @(posedge clk); #1;
    addr_phase(d, a, w, sz);
    @(posedge clk); #1;
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    hwdata[d] = wd;
    hwstrb[d] = st;
    wait_ready(d);
    @(posedge clk); #1;
    hwstrb[d] = 8'h00;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = '0;
      hwrite[d] = 1'b0; hsize[d] = 3'd3; hwdata[d] = '0; hwstrb[d] = '0;
      last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_eq("rst_readyout", 64'(hreadyout[d]), 64'd1);
      chk_eq("rst_resp", 64'(hresp[d]), 64'd0);
      chk_eq("rst_rdata", hrdata[d], 64'd0);
    end

    // Full-word write/read, zero waits
    xfer(0, 32'h100, 1'b1, 3'd3, 64'h1122334455667788, 8'hFF, "t1_wr");
    xfer(0, 32'h100, 1'b0, 3'd3, 64'd0, 8'h00, "t1_rd");

    // Partial strobes and an all-zero strobe
    xfer(0, 32'h8, 1'b1, 3'd3, 64'd0, 8'hFF, "t3_clr");
    xfer(0, 32'h8, 1'b1, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, "t3_wr");
    xfer(0, 32'h8, 1'b0, 3'd3, 64'd0, 8'h00, "t3_rd");
    xfer(0, 32'h8, 1'b1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00, "strb0_wr");
    xfer(0, 32'h8, 1'b0, 3'd3, 64'd0, 8'h00, "strb0_rd");

    // Back-to-back write then read of the same word
    xfer(0, 32'h40, 1'b1, 3'd3, 64'd0, 8'hFF, "t4_clr");
    sbq.push_back(predict(0, 32'h40, 1'b1, 3'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, "t4_wr"));
    sbq.push_back(predict(0, 32'h40, 1'b0, 3'd3, 64'd0, 8'h00, "t4_rd"));
    @(posedge clk); #1;
    addr_phase(0, 32'h40, 1'b1, 3'd3);
    @(posedge clk); #1;
    addr_phase(0, 32'h40, 1'b0, 3'd3);
    hwdata[0] = 64'hDEADBEEFCAFEF00D;
    hwstrb[0] = 8'hFF;
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwstrb[0] = 8'h00;
    wait_ready(0);
    @(posedge clk); #1;

    // Error responses: out of range, misaligned, oversize
    xfer(0, 32'h0, 1'b1, 3'd3, 64'h0, 8'hFF, "t5_clr");
    xfer(0, 32'(DEPTH * 8), 1'b0, 3'd3, 64'd0, 8'h00, "t5_oor_rd");
    xfer(0, 32'h4, 1'b1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, "t5_mis_wr");
    xfer(0, 32'h0, 3'd4 == 3'd4 ? 1'b0 : 1'b0, 3'd4, 64'd0, 8'h00, "t5_size_rd");
    xfer(0, 32'h0, 1'b0, 3'd3, 64'd0, 8'h00, "t5_rd0");
    xfer(0, 32'h4, 1'b0, 3'd2, 64'd0, 8'h00, "t5_word_rd");

    // Three wait states
    xfer(1, 32'h100, 1'b1, 3'd3, 64'h0F1E2D3C4B5A6978, 8'hFF, "t2_wr");
    xfer(1, 32'h100, 1'b0, 3'd3, 64'd0, 8'h00, "t2_rd");

    // Reset during the wait phase of a write
    xfer(1, 32'h20, 1'b1, 3'd3, 64'h0123456789ABCDEF, 8'hFF, "t6_init");
    @(posedge clk); #1;
    addr_phase(1, 32'h20, 1'b1, 3'd3);
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00;
    hwdata[1] = 64'hFFFFFFFFFFFFFFFF; hwstrb[1] = 8'hFF;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    hwstrb[1] = 8'h00;
    last_rd[1] = '0;
    @(negedge clk);
    chk_eq("t6_readyout", 64'(hreadyout[1]), 64'd1);
    chk_eq("t6_resp", 64'(hresp[1]), 64'd0);
    chk_eq("t6_rdata", hrdata[1], 64'd0);
    xfer(1, 32'h20, 1'b0, 3'd3, 64'd0, 8'h00, "t6_rd");

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    chk_eq("sb_drain", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
